// File: rtl/receive_all_if.sv
`default_nettype none
// ============================================================================
// receive_all_if : inter-board Request/Ack link plus decoded message bus
// Rev 1.0
// ============================================================================
interface receive_all_if;
  logic       Request;
  logic [5:0] interboard_data;
  logic       Ack;
  logic       msg_valid;
  logic [3:0] msg_type;
  logic [4:0] block_x;
  logic [2:0] block_y;
  logic [5:0] card;
  logic [2:0] sel_len;
  logic       move_dir;
  logic       remote_rst;

  // master: remote sender / game-control side; slave: the receiver
  modport master (
    output Request, interboard_data,
    input  Ack, msg_valid, msg_type, block_x, block_y, card, sel_len,
           move_dir, remote_rst
  );

  modport slave (
    input  Request, interboard_data,
    output Ack, msg_valid, msg_type, block_x, block_y, card, sel_len,
           move_dir, remote_rst
  );
endinterface
`default_nettype wire

// File: rtl/receive_all.sv
`default_nettype none
// ============================================================================
// receive_all : 4-phase Request/Ack receiver assembling six-word game messages
// Rev 1.0
// ============================================================================
module receive_all #(
  parameter int SYNC_STAGES   = 2,
  parameter int RST_HOLD      = 16,
  parameter int FRAME_TIMEOUT = 1_000_000
) (
  input logic          clk,
  input logic          rst_n,
  receive_all_if.slave bus
);

  localparam int c_rst_w = $clog2(RST_HOLD + 1);
  localparam int c_to_w  = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [c_rst_w-1:0] c_rst_max  = c_rst_w'(RST_HOLD);
  localparam logic [c_rst_w-1:0] c_rst_last = c_rst_w'(RST_HOLD - 1);
  localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(FRAME_TIMEOUT - 1);

  typedef enum logic [1:0] {
    WAIT_REQ_UP = 2'd0,
    ACK_HIGH    = 2'd1,
    ACK_LOW     = 2'd2,
    REMOTE_RST  = 2'd3
  } state_t;

  state_t r_state, w_state_next;

  logic [SYNC_STAGES-1:0] r_req_sync;
  logic                   w_req_s;
  logic [5:0]             r_data_s;
  logic [2:0]             r_idx;
  logic [3:0]             r_w0;
  logic [4:0]             r_w1;
  logic [2:0]             r_w2;
  logic [5:0]             r_w3;
  logic [2:0]             r_w4;
  logic [c_rst_w-1:0]     r_rst_cnt;
  logic [c_to_w-1:0]      r_to_cnt;
  logic                   r_ack, r_msg_valid, r_remote_rst;
  logic [3:0]             r_msg_type;
  logic [4:0]             r_block_x;
  logic [2:0]             r_block_y;
  logic [5:0]             r_card;
  logic [2:0]             r_sel_len;
  logic                   r_move_dir;

  logic w_capture, w_word_done, w_frame_load, w_rst_inc, w_rrst_hit;
  logic w_to_run, w_timeout;

  assign w_req_s    = r_req_sync[SYNC_STAGES-1];
  // Raw data is used here: it is only qualified by the synchronized Request
  assign w_rst_inc  = w_req_s && (bus.interboard_data == 6'h3F);
  assign w_rrst_hit = w_rst_inc && (r_rst_cnt == c_rst_last);
  assign w_to_run   = (r_state == WAIT_REQ_UP) && (r_idx != 3'd0) && !w_req_s;
  assign w_timeout  = w_to_run && (r_to_cnt == c_to_last);

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_word_done  = 1'b0;
    w_frame_load = 1'b0;
    if (w_rrst_hit) begin
      w_state_next = REMOTE_RST;
    end else begin
      case (r_state)
        WAIT_REQ_UP: if (w_req_s) begin
          w_capture    = 1'b1;
          w_state_next = ACK_HIGH;
        end
        ACK_HIGH: if (!w_req_s) begin
          w_state_next = ACK_LOW;
          w_frame_load = (r_idx == 3'd5);
        end
        ACK_LOW: begin
          w_word_done  = 1'b1;
          w_state_next = WAIT_REQ_UP;
        end
        REMOTE_RST: if (!w_req_s) w_state_next = WAIT_REQ_UP;
        default: w_state_next = WAIT_REQ_UP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= WAIT_REQ_UP;
      r_req_sync   <= '0;
      r_data_s     <= '0;
      r_idx        <= '0;
      r_w0         <= '0;
      r_w1         <= '0;
      r_w2         <= '0;
      r_w3         <= '0;
      r_w4         <= '0;
      r_rst_cnt    <= '0;
      r_to_cnt     <= '0;
      r_ack        <= 1'b0;
      r_msg_valid  <= 1'b0;
      r_remote_rst <= 1'b0;
      r_msg_type   <= '0;
      r_block_x    <= '0;
      r_block_y    <= '0;
      r_card       <= '0;
      r_sel_len    <= '0;
      r_move_dir   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], bus.Request};

      if (w_capture) r_data_s <= bus.interboard_data;

      case (w_state_next)
        ACK_HIGH:   r_ack <= 1'b1;
        REMOTE_RST: r_ack <= r_ack;  // sender ignores Ack during remote reset
        default:    r_ack <= 1'b0;
      endcase
      r_remote_rst <= (w_state_next == REMOTE_RST);

      if (!w_rst_inc)              r_rst_cnt <= '0;
      else if (r_rst_cnt != c_rst_max) r_rst_cnt <= r_rst_cnt + 1'b1;

      r_to_cnt <= (w_to_run && !w_timeout) ? r_to_cnt + 1'b1 : '0;

      if (w_state_next == REMOTE_RST)             r_idx <= '0;
      else if (w_word_done && r_idx == 3'd5)      r_idx <= '0;
      else if (w_word_done)                       r_idx <= r_idx + 3'd1;
      else if (w_timeout)                         r_idx <= '0;

      if (w_word_done) begin
        case (r_idx)
          3'd0:    r_w0 <= r_data_s[3:0];
          3'd1:    r_w1 <= r_data_s[4:0];
          3'd2:    r_w2 <= r_data_s[2:0];
          3'd3:    r_w3 <= r_data_s;
          3'd4:    r_w4 <= r_data_s[2:0];
          default: ;
        endcase
      end

      // Word 5 still sits in r_data_s; load the whole frame atomically
      r_msg_valid <= w_frame_load;
      if (w_frame_load) begin
        r_msg_type <= r_w0;
        r_block_x  <= r_w1;
        r_block_y  <= r_w2;
        r_card     <= r_w3;
        r_sel_len  <= r_w4;
        r_move_dir <= r_data_s[0];
      end
    end
  end

  assign bus.Ack        = r_ack;
  assign bus.msg_valid  = r_msg_valid;
  assign bus.remote_rst = r_remote_rst;
  assign bus.msg_type   = r_msg_type;
  assign bus.block_x    = r_block_x;
  assign bus.block_y    = r_block_y;
  assign bus.card       = r_card;
  assign bus.sel_len    = r_sel_len;
  assign bus.move_dir   = r_move_dir;

endmodule
`default_nettype wire

// File: tb/tb_receive_all.sv
`default_nettype none
// ============================================================================
// tb_receive_all : directed self-checking bench for receive_all
// Rev 1.0
// ============================================================================
module tb_receive_all;
  localparam int SYNC_STAGES   = 2;
  localparam int RST_HOLD      = 16;
  localparam int FRAME_TIMEOUT = 50;
  localparam int LAT           = SYNC_STAGES + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  receive_all_if bus();

  receive_all #(
    .SYNC_STAGES  (SYNC_STAGES),
    .RST_HOLD     (RST_HOLD),
    .FRAME_TIMEOUT(FRAME_TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int valid_cnt = 0, ack_rises = 0, rrst_cycles = 0;
  logic prev_ack = 1'b0;
  int v0, a0, r0;

  always @(negedge clk) begin
    if (bus.msg_valid) valid_cnt++;
    if (bus.remote_rst) rrst_cycles++;
    if (bus.Ack && !prev_ack) ack_rises++;
    prev_ack = bus.Ack;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic send_word(input logic [5:0] d);
    int n;
    n = 0;
    bus.interboard_data = d;
    bus.Request = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.Ack && n < 20);
    check("ack_rise_latency", n, LAT);
    bus.interboard_data = 6'h00;  // must not be recaptured while Ack is high
    bus.Request = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.Ack && n < 20);
    check("ack_fall_latency", (n <= LAT) ? 1 : 0, 1);
  endtask

  task automatic send_frame(input logic [5:0] w0, w1, w2, w3, w4, w5);
    send_word(w0); send_word(w1); send_word(w2);
    send_word(w3); send_word(w4); send_word(w5);
    #1;
  endtask

  task automatic check_msg(input string tag, input logic [3:0] t, input logic [4:0] x,
                           input logic [2:0] y, input logic [5:0] c,
                           input logic [2:0] s, input logic m);
    check({tag, ".msg_type"}, bus.msg_type, t);
    check({tag, ".block_x"},  bus.block_x,  x);
    check({tag, ".block_y"},  bus.block_y,  y);
    check({tag, ".card"},     bus.card,     c);
    check({tag, ".sel_len"},  bus.sel_len,  s);
    check({tag, ".move_dir"}, bus.move_dir, m);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.Request = 1'b0;
    bus.interboard_data = 6'h00;
    repeat (3) @(negedge clk);
    check("rst.Ack", bus.Ack, 0);
    check("rst.msg_valid", bus.msg_valid, 0);
    check("rst.remote_rst", bus.remote_rst, 0);
    check_msg("rst", 4'd0, 5'd0, 3'd0, 6'd0, 3'd0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal frame
    v0 = valid_cnt; a0 = ack_rises;
    send_frame(6'h05, 6'h13, 6'h06, 6'h2A, 6'h03, 6'h01);
    check("normal.valid_pulses", valid_cnt - v0, 1);
    check("normal.ack_toggles", ack_rises - a0, 6);
    check_msg("normal", 4'd5, 5'd19, 3'd6, 6'd42, 3'd3, 1'b1);

    // Remote reset after word 2 of a frame
    v0 = valid_cnt;
    send_word(6'h11); send_word(6'h02); send_word(6'h03);
    bus.interboard_data = 6'h3F;
    bus.Request = 1'b1;
    repeat (SYNC_STAGES + RST_HOLD - 1) @(negedge clk);
    check("rrst.before_hold", bus.remote_rst, 0);
    @(negedge clk);
    check("rrst.at_hold", bus.remote_rst, 1);
    check("rrst.ack_held", bus.Ack, 1);
    repeat (2) @(negedge clk);
    check("rrst.still_set", bus.remote_rst, 1);
    check("rrst.no_valid", valid_cnt - v0, 0);
    check_msg("rrst.hold", 4'd5, 5'd19, 3'd6, 6'd42, 3'd3, 1'b1);
    bus.Request = 1'b0;
    bus.interboard_data = 6'h00;
    repeat (LAT) @(negedge clk);
    check("rrst.cleared", bus.remote_rst, 0);
    check("rrst.ack_low", bus.Ack, 0);
    v0 = valid_cnt;
    // upper data bits beyond each field's width are ignored
    send_frame(6'h39, 6'h3F, 6'h2F, 6'h01, 6'h0F, 6'h3E);
    check("after_rrst.valid_pulses", valid_cnt - v0, 1);
    check_msg("after_rrst", 4'd9, 5'd31, 3'd7, 6'd1, 3'd7, 1'b0);

    // Card value 63 as ordinary data
    v0 = valid_cnt; r0 = rrst_cycles;
    send_frame(6'h02, 6'h04, 6'h01, 6'h3F, 6'h00, 6'h01);
    check("card63.valid_pulses", valid_cnt - v0, 1);
    check("card63.no_remote_rst", rrst_cycles - r0, 0);
    check_msg("card63", 4'd2, 5'd4, 3'd1, 6'd63, 3'd0, 1'b1);

    // Frame timeout discards a partial frame
    v0 = valid_cnt;
    send_word(6'h07); send_word(6'h08); send_word(6'h09);
    repeat (FRAME_TIMEOUT + 10) @(negedge clk);
    check("timeout.no_valid", valid_cnt - v0, 0);
    check_msg("timeout.hold", 4'd2, 5'd4, 3'd1, 6'd63, 3'd0, 1'b1);
    send_frame(6'h0A, 6'h0A, 6'h02, 6'h15, 6'h05, 6'h01);
    check("timeout.fresh_valid", valid_cnt - v0, 1);
    check_msg("timeout.fresh", 4'd10, 5'd10, 3'd2, 6'd21, 3'd5, 1'b1);

    // Asynchronous reset while Ack is high
    bus.interboard_data = 6'h05;
    bus.Request = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.Ack && n < 20);
    check("areset.ack_before", bus.Ack, 1);
    #2 rst_n = 1'b0;
    #1;
    check("areset.Ack", bus.Ack, 0);
    check("areset.msg_valid", bus.msg_valid, 0);
    check("areset.remote_rst", bus.remote_rst, 0);
    check_msg("areset", 4'd0, 5'd0, 3'd0, 6'd0, 3'd0, 1'b0);
    bus.Request = 1'b0;
    bus.interboard_data = 6'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    v0 = valid_cnt;
    send_frame(6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h00);
    check("areset.frame_valid", valid_cnt - v0, 1);
    check_msg("areset.frame", 4'd1, 5'd2, 3'd3, 6'd4, 3'd5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/receive_all.md
Name: receive_all

Overview:
- Receiving end of the inter-board 4-phase Request/Ack link.
- Samples the asynchronous Request and 6-bit data bus from the other board, acknowledges each word, and assembles six consecutive words into one game message: msg_type, block_x, block_y, card, sel_len, move_dir.
- Presents the message to GameControl with a one-cycle valid pulse.
- Detects the other board's reset indication: all-ones data with Request held high.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on the Request input (minimum 2).
- RST_HOLD, 16, consecutive cycles of synchronized Request=1 with data=6'b111111 required to flag a remote reset.
- FRAME_TIMEOUT, 1_000_000, idle cycles allowed between words of one frame before the partial frame is discarded.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- Request  input  1  from other board, asynchronous
- interboard_data  input  6  from other board, asynchronous, stable while Request=1
- Ack  output  1  to other board
- msg_valid  output  1  one-cycle pulse: a full frame has been received
- msg_type  output  4  word 0 [3:0]
- block_x  output  5  word 1 [4:0]
- block_y  output  3  word 2 [2:0]
- card  output  6  word 3 [5:0]
- sel_len  output  3  word 4 [2:0]
- move_dir  output  1  word 5 [0]
- remote_rst  output  1  level: the other board is asserting interboard reset

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Ack=0, msg_valid=0, remote_rst=0.
  - All message outputs are 0.
  - Word index is 0, the FSM is in WAIT_REQ_UP, and all counters are 0.
- Synchronization:
  - Request passes through SYNC_STAGES flops to give req_s.
  - interboard_data is registered into data_s on the cycle req_s is first seen high.
  - Data is never sampled while req_s=0.
- FSM:
  - WAIT_REQ_UP: when req_s=1, capture data_s into the slot selected by word index, then go to ACK_HIGH.
  - ACK_HIGH: Ack=1 (registered). When req_s=0, go to ACK_LOW.
  - ACK_LOW: Ack=0. Word index increments.
    - If the index was 5, load all six slots to the outputs, pulse msg_valid for exactly 1 cycle, and reset the index to 0.
    - Return to WAIT_REQ_UP.
- Latency:
  - Ack rises SYNC_STAGES+1 cycles after Request rises.
  - Ack falls in the cycle after req_s falls.
  - msg_valid fires in the ACK_LOW cycle of word 5.
- Output hold:
  - Message outputs hold their previous frame values until the next complete frame.
  - Partially received frames never alter the outputs.
- Remote reset detection:
  - A counter increments each cycle that req_s=1 and raw data=6'b111111. Any other cycle clears it.
  - When the counter reaches RST_HOLD, remote_rst=1, the word index is forced to 0, and the partial frame is discarded. Ack stays at its current value (the sender ignores it).
  - remote_rst stays 1 until req_s=0. It then clears, and the FSM goes to WAIT_REQ_UP with Ack=0.
  - A single word 6'b111111 acknowledged normally (Request drops before RST_HOLD) is legal data, e.g. card=63.
- Frame timeout:
  - In WAIT_REQ_UP with word index ≠0, a counter counts idle cycles.
  - At FRAME_TIMEOUT the index returns to 0 with no msg_valid and no output change.
  - The counter clears on each new word.
- Simultaneous events: remote reset detection has priority over frame completion.
- Reset mid-frame: asynchronous reset clears everything. The sender's next word is treated as word 0.
- Width rule: unused upper data bits of words 0, 1, 2, 4 and 5 are ignored, with no error.

Test Plan:
- Normal frame: words 0x5, 0x13, 0x6, 0x2A, 0x3, 0x1 with full handshakes -> a single msg_valid pulse with msg_type=5, block_x=19, block_y=6, card=42, sel_len=3, move_dir=1. Ack toggles 6 times.
- Handshake timing: raise Request -> Ack=1 exactly SYNC_STAGES+1 cycles later. Drop Request -> Ack=0 at most SYNC_STAGES+1 cycles later. No capture while Ack is high.
- Remote reset: hold Request=1 with data=0x3F for 20 cycles after word 2 of a frame -> remote_rst=1 at cycle RST_HOLD and outputs unchanged. Drop Request -> remote_rst=0. A new 6-word frame then decodes correctly.
- Card 63: a frame with card word 0x3F and normal handshake -> card=63, remote_rst stays 0.
- Timeout: send 3 words and then idle for FRAME_TIMEOUT cycles (use a small parameter) -> no msg_valid. The next 6 words decode as a fresh frame.
- Async reset: assert rst_n=0 mid-ACK_HIGH -> Ack=0 immediately and all outputs 0. After release, a full frame decodes.
